// File: rtl/bank_master_if.sv
// Command/response handshake and memory-bank strobe bundle for bank_master.
// The master modport is the bank_master side; slave is the core/loader plus bank side.
interface bank_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [7:0] cmd_len;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       bank_read;
  logic       bank_write;
  logic [7:0] bank_addr;
  logic [7:0] bank_wdata;
  logic [7:0] bank_rdata;
  logic       bank_finish;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, rsp_ready,
           bank_rdata, bank_finish,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           bank_read, bank_write, bank_addr, bank_wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, rsp_ready,
           bank_rdata, bank_finish,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           bank_read, bank_write, bank_addr, bank_wdata
  );
endinterface

// File: rtl/bank_master.sv
// Initiator for a 256x8 memory bank: single read/write and multi-beat fill,
// one beat outstanding at a time, with a per-beat finish timeout.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | one-cycle bank strobe for the current beat
// WAIT  | strobes low, waiting for bank_finish or timeout
// RESP  | response held until rsp_ready
module bank_master #(
  parameter int TIMEOUT = 8
) (
  input  logic clock,
  input  logic reset,
  bank_master_if.master bus,
  output logic busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam logic [7:0] TMO     = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [1:0] op_q, op_nxt;
  logic [7:0] addr_q, addr_nxt;
  logic [7:0] data_q, data_nxt;
  logic [7:0] remain_q, remain_nxt;
  logic [7:0] tcnt_q, tcnt_nxt;
  logic       rsp_valid_q, rsp_valid_nxt;
  logic       rsp_err_q, rsp_err_nxt;
  logic [7:0] rsp_data_q, rsp_data_nxt;
  logic       rd_q, rd_nxt;
  logic       wr_q, wr_nxt;
  logic [7:0] baddr_q, baddr_nxt;
  logic [7:0] bwdata_q, bwdata_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= 2'b00;
      addr_q      <= 8'd0;
      data_q      <= 8'd0;
      remain_q    <= 8'd0;
      tcnt_q      <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 8'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      baddr_q     <= 8'd0;
      bwdata_q    <= 8'd0;
    end else begin
      state       <= state_nxt;
      op_q        <= op_nxt;
      addr_q      <= addr_nxt;
      data_q      <= data_nxt;
      remain_q    <= remain_nxt;
      tcnt_q      <= tcnt_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rsp_data_q  <= rsp_data_nxt;
      rd_q        <= rd_nxt;
      wr_q        <= wr_nxt;
      baddr_q     <= baddr_nxt;
      bwdata_q    <= bwdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    op_nxt        = op_q;
    addr_nxt      = addr_q;
    data_nxt      = data_q;
    remain_nxt    = remain_q;
    tcnt_nxt      = tcnt_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_err_nxt   = rsp_err_q;
    rsp_data_nxt  = rsp_data_q;
    rd_nxt        = 1'b0;
    wr_nxt        = 1'b0;
    baddr_nxt     = baddr_q;
    bwdata_nxt    = bwdata_q;

    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_nxt     = bus.cmd_op;
          addr_nxt   = bus.cmd_addr;
          data_nxt   = bus.cmd_data;
          remain_nxt = (bus.cmd_op == OP_FILL) ? bus.cmd_len : 8'd0;
          if (bus.cmd_op == OP_RSVD) begin
            state_nxt     = S_RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = 8'd0;
          end else begin
            state_nxt  = S_ISSUE;
            rd_nxt     = (bus.cmd_op == OP_READ);
            wr_nxt     = (bus.cmd_op != OP_READ);
            baddr_nxt  = bus.cmd_addr;
            bwdata_nxt = (bus.cmd_op == OP_READ) ? 8'd0 : bus.cmd_data;
          end
        end
      end

      S_ISSUE: begin
        state_nxt = S_WAIT;
        tcnt_nxt  = 8'd0;
      end

      S_WAIT: begin
        // A finish arriving on the terminal-count cycle still wins over the timeout.
        if (bus.bank_finish) begin
          if (op_q == OP_FILL && remain_q != 8'd0) begin
            state_nxt  = S_ISSUE;
            addr_nxt   = addr_q + 8'd1;
            remain_nxt = remain_q - 8'd1;
            wr_nxt     = 1'b1;
            baddr_nxt  = addr_q + 8'd1;
            bwdata_nxt = data_q;
          end else begin
            state_nxt     = S_RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b0;
            rsp_data_nxt  = (op_q == OP_READ) ? bus.bank_rdata : 8'd0;
          end
        end else begin
          tcnt_nxt = tcnt_q + 8'd1;
          if (tcnt_nxt == TMO) begin
            state_nxt     = S_RESP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = 8'd0;
          end
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b0;
          rsp_err_nxt   = 1'b0;
          rsp_data_nxt  = 8'd0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.cmd_ready  = (state == S_IDLE);
  assign busy           = (state != S_IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.bank_read  = rd_q;
  assign bus.bank_write = wr_q;
  assign bus.bank_addr  = baddr_q;
  assign bus.bank_wdata = bwdata_q;

endmodule

// File: tb/tb_bank_master.sv
// Bench for bank_master: directed scenarios plus randomized commands against
// a reference model of expected strobes, latency, response and bank contents.
module tb_bank_master;
  localparam int TMO = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic busy;

  bank_master_if bus();

  bank_master #(.TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] bank_mem [256];
  logic [7:0] ref_mem  [256];
  bit alive = 1'b1;
  bit spur = 1'b0;
  bit model_fin = 1'b0;
  bit pend = 1'b0;
  bit b2b = 1'b0;
  logic [7:0] pend_addr = 8'd0;

  typedef struct {
    int         cyc;
    bit         rd;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } strobe_t;
  strobe_t slog[$];

  assign bus.bank_finish = model_fin | spur;

  // Bank responder: finish one cycle after each strobe, sampled mid-cycle.
  always @(negedge clock) begin
    model_fin = 1'b0;
    bus.bank_rdata = 8'h00;
    if (pend && alive) begin
      model_fin = 1'b1;
      bus.bank_rdata = bank_mem[pend_addr];
    end
    pend = 1'b0;
    if (reset && (bus.bank_read || bus.bank_write)) begin
      slog.push_back(strobe_t'{cyc, bus.bank_read, bus.bank_write, bus.bank_addr, bus.bank_wdata});
      pend = 1'b1;
      pend_addr = bus.bank_addr;
      if (bus.bank_write && alive) bank_mem[bus.bank_addr] = bus.bank_wdata;
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                         input logic [7:0] len, input bit live, input int hold, input int spur_at,
                         output int t0);
    int exp_lat, beats, lat, n;
    bit exp_err, ready_ok;
    logic [7:0] exp_data, a;
    alive = live;
    if (op == 2'b11) begin
      exp_err = 1'b1; exp_data = 8'd0; beats = 0; exp_lat = 0;
    end else if (!live) begin
      exp_err = 1'b1; exp_data = 8'd0; beats = 1; exp_lat = TMO + 1;
    end else begin
      beats = (op == 2'b10) ? int'(len) + 1 : 1;
      exp_err = 1'b0;
      exp_data = (op == 2'b00) ? ref_mem[addr] : 8'd0;
      exp_lat = 2 * beats;
      if (op != 2'b00)
        for (int i = 0; i < beats; i++) begin
          a = addr + 8'(i);
          ref_mem[a] = data;
        end
    end
    slog.delete();
    bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data; bus.cmd_len = len;
    bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom); bus.cmd_addr = 8'($urandom);
    bus.cmd_data = 8'($urandom); bus.cmd_len = 8'($urandom);
    ready_ok = 1'b1;
    lat = -1;
    for (int k = 0; k < 600; k++) begin
      if (bus.rsp_valid) begin
        lat = cyc - t0;
        break;
      end
      if (bus.cmd_ready !== 1'b0) ready_ok = 1'b0;
      @(posedge clock); #1;
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL latency op=%0d got=%0d want=%0d (-1 = no response)", op, lat, exp_lat);
    end
    checks++;
    if (!ready_ok) begin
      failures++;
      $display("FAIL cmd_ready_busy op=%0d got=1 want=0", op);
    end
    checks++;
    if (bus.rsp_err !== exp_err) begin
      failures++;
      $display("FAIL rsp_err op=%0d got=%b want=%b", op, bus.rsp_err, exp_err);
    end
    checks++;
    if (bus.rsp_data !== exp_data) begin
      failures++;
      $display("FAIL rsp_data op=%0d got=%h want=%h", op, bus.rsp_data, exp_data);
    end
    for (int h = 0; h < hold; h++) begin
      if (h == spur_at) spur = 1'b1;
      @(posedge clock); #1;
      spur = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data || bus.rsp_err !== exp_err ||
          bus.cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable h=%0d got v=%b d=%h e=%b rdy=%b want v=1 d=%h e=%b rdy=0",
                 h, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.cmd_ready, exp_data, exp_err);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clock); #1;
    if (!b2b) bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 8'd0 ||
        bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL post_handshake got v=%b e=%b d=%h rdy=%b busy=%b want 0 0 00 1 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.cmd_ready, busy);
    end
    checks++;
    if (slog.size() != beats) begin
      failures++;
      $display("FAIL strobe_count op=%0d got=%0d want=%0d", op, slog.size(), beats);
    end
    n = (slog.size() < beats) ? slog.size() : beats;
    for (int i = 0; i < n; i++) begin
      a = addr + 8'(i);
      checks++;
      if (slog[i].cyc != t0 + 2 * i || slog[i].rd != (op == 2'b00) || slog[i].wr != (op != 2'b00) ||
          slog[i].addr !== a || slog[i].wdata !== ((op == 2'b00) ? 8'd0 : data)) begin
        failures++;
        $display("FAIL strobe_%0d got cyc=%0d rd=%b wr=%b a=%h d=%h want cyc=%0d rd=%b wr=%b a=%h d=%h",
                 i, slog[i].cyc - t0, slog[i].rd, slog[i].wr, slog[i].addr, slog[i].wdata,
                 2 * i, op == 2'b00, op != 2'b00, a, (op == 2'b00) ? 8'd0 : data);
      end
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 256; i++)
      if (bank_mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s bad_bytes=%0d first_addr=%0d got=%h want=%h", name, bad, first,
               bank_mem[first], ref_mem[first]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_data !== 8'd0 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_rsp got rdy=%b busy=%b v=%b d=%h e=%b want 1 0 0 00 0", name,
               bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_data, bus.rsp_err);
    end
    checks++;
    if (bus.bank_read !== 1'b0 || bus.bank_write !== 1'b0 || bus.bank_addr !== 8'd0 ||
        bus.bank_wdata !== 8'd0) begin
      failures++;
      $display("FAIL %s_bank got rd=%b wr=%b a=%h d=%h want 0 0 00 00", name,
               bus.bank_read, bus.bank_write, bus.bank_addr, bus.bank_wdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_write_read();
    int t;
    run_cmd(2'b01, 8'h10, 8'hA5, 8'h00, 1'b1, 0, -1, t);
    run_cmd(2'b00, 8'h10, 8'h00, 8'h00, 1'b1, 0, -1, t);
  endtask

  task automatic test_fill_wrap();
    int t;
    run_cmd(2'b10, 8'hFE, 8'h3C, 8'd3, 1'b1, 0, -1, t);
    check_mem("fill_wrap_mem");
  endtask

  task automatic test_timeout();
    int t;
    run_cmd(2'b00, 8'h20, 8'h00, 8'h00, 1'b0, 0, -1, t);
    run_cmd(2'b10, 8'h40, 8'h77, 8'd5, 1'b0, 0, -1, t);
    check_mem("timeout_mem");
  endtask

  task automatic test_reserved();
    int t;
    run_cmd(2'b11, 8'h33, 8'h44, 8'h00, 1'b1, 3, -1, t);
  endtask

  task automatic test_rsp_hold();
    int t;
    run_cmd(2'b01, 8'h55, 8'h5A, 8'h00, 1'b1, 0, -1, t);
    run_cmd(2'b00, 8'h55, 8'h00, 8'h00, 1'b1, 5, 2, t);
  endtask

  task automatic test_back_to_back();
    int t_prev, t;
    b2b = 1'b1;
    bus.rsp_ready = 1'b1;
    run_cmd(2'b01, 8'($urandom), 8'($urandom), 8'h00, 1'b1, 0, -1, t_prev);
    for (int i = 0; i < 4; i++) begin
      run_cmd((i % 2 == 0) ? 2'b00 : 2'b01, 8'($urandom), 8'($urandom), 8'h00, 1'b1, 0, -1, t);
      checks++;
      if (t - t_prev != 4) begin
        failures++;
        $display("FAIL b2b_spacing i=%0d got=%0d want=4", i, t - t_prev);
      end
      t_prev = t;
    end
    b2b = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int t;
    bit quiet = 1'b1;
    alive = 1'b1;
    bus.cmd_op = 2'b10; bus.cmd_addr = 8'h80; bus.cmd_data = 8'h99; bus.cmd_len = 8'd4;
    bus.cmd_valid = 1'b1;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clock); #1;
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    ref_mem[8'h80] = 8'h99;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL reset_mid_no_rsp got activity want idle");
    end
    run_cmd(2'b00, 8'h80, 8'h00, 8'h00, 1'b1, 0, -1, t);
  endtask

  task automatic test_random();
    int t, r;
    logic [1:0] op;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      run_cmd(op, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 7)),
              $urandom_range(0, 5) != 0, $urandom_range(0, 2), -1, t);
    end
    check_mem("random_mem");
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_addr = 8'd0;
    bus.cmd_data = 8'd0;
    bus.cmd_len = 8'd0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bank_mem[i] = 8'($urandom);
      ref_mem[i] = bank_mem[i];
    end
    test_reset();
    test_write_read();
    test_fill_wrap();
    test_timeout();
    test_reserved();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
